ex_muldiv_seq: RTL and testbench

//   Multi-cycle sequencer for the RV32M multiply/divide path of the execute stage.

---
 rtl/ex_muldiv_seq.sv | 197 +++++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - iterative RV32M multiply/divide sequencer for the execute stage
//
// Purpose: accepts one M-extension op, runs a radix-2 shift-add multiply or
// restoring divide over XLEN cycles, stalls the pipeline through busy and
// returns one XLEN-bit result with a single-cycle resp_valid strobe.
//
// Ports:
//   clk         in   1     system clock, rising edge
//   rst         in   1     asynchronous active-low reset
//   req_valid   in   1     EX holds a valid M-op
//   req_ready   out  1     sequencer idle and able to accept
//   req_fun_3   in   3     0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   req_op1     in   XLEN  rs1 (multiplicand / dividend)
//   req_op2     in   XLEN  rs2 (multiplier / divisor)
//   flush       in   1     synchronous kill, returns to IDLE
//   busy        out  1     pipeline stall request
//   resp_valid  out  1     one-cycle result strobe
//   resp_data   out  XLEN  result, held until the next strobe

module ex_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_fun_3,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  input  logic            flush,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_fun_3;
  logic              r_neg_res;   // product / quotient must be negated
  logic              r_neg_rem;   // remainder takes the dividend sign
  logic [2*XLEN-1:0] r_acc;       // mul: {hi, multiplier/lo}; div: {rem, dividend/quot}
  logic [XLEN-1:0]   r_opb;       // multiplicand or divisor magnitude
  logic [XLEN-1:0]   r_result;
  logic [XLEN-1:0]   r_resp_data;

  logic              w_accept;
  logic              w_sgn1;
  logic              w_sgn2;
  logic              w_neg1;
  logic              w_neg2;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN-1:0]   w_spec_res;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  // A flush landing in DONE suppresses the strobe in the same cycle.
  assign resp_valid = (r_state == S_DONE) && !flush;
  assign resp_data  = resp_valid ? r_result : r_resp_data;

  assign w_accept = req_valid && req_ready && !flush;

  always_comb begin
    w_sgn1 = 1'b0;
    w_sgn2 = 1'b0;
    case (req_fun_3)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        w_sgn1 = 1'b1;
        w_sgn2 = 1'b1;
      end
      3'd2:    w_sgn1 = 1'b1;
      default: ;
    endcase
  end

  assign w_neg1 = w_sgn1 && req_op1[XLEN-1];
  assign w_neg2 = w_sgn2 && req_op2[XLEN-1];
  // Negating MIN_NEG yields MIN_NEG, which is exactly the unsigned magnitude 2^(XLEN-1).
  assign w_mag1 = w_neg1 ? -req_op1 : req_op1;
  assign w_mag2 = w_neg2 ? -req_op2 : req_op2;

  assign w_div0 = req_fun_3[2] && (req_op2 == '0);
  assign w_ovf  = req_fun_3[2] && !req_fun_3[0] &&
                  (req_op1 == MIN_NEG) && (req_op2 == ALL_ONE);

  always_comb begin
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = req_fun_3[1] ? req_op1 : ALL_ONE;
    else if (w_ovf)
      w_spec_res = req_fun_3[1] ? '0 : MIN_NEG;
  end

  // Shift-add step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring step: shift in the next dividend bit, trial-subtract the divisor,
  // keep the difference only when it did not go negative.
  assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_opb};
  assign w_div_next = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quot = r_acc[XLEN-1:0];
  assign w_rem  = r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    if (!r_fun_3[2])
      w_fix_res = (r_fun_3[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    else if (r_fun_3[1])
      w_fix_res = r_neg_rem ? -w_rem : w_rem;
    else
      w_fix_res = r_neg_res ? -w_quot : w_quot;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_fun_3     <= '0;
      r_neg_res   <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_acc       <= '0;
      r_opb       <= '0;
      r_result    <= '0;
      r_resp_data <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_fun_3   <= req_fun_3;
            r_neg_res <= w_neg1 ^ w_neg2;
            r_neg_rem <= w_neg1;
            if (req_fun_3[2]) begin
              r_acc <= {{XLEN{1'b0}}, w_mag1};
              r_opb <= w_mag2;
            end else begin
              r_acc <= {{XLEN{1'b0}}, w_mag2};
              r_opb <= w_mag1;
            end
            if (w_div0 || w_ovf) begin
              r_result <= w_spec_res;
              r_state  <= S_DONE;
            end else begin
              r_cnt   <= CW'(XLEN - 1);
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc <= r_fun_3[2] ? w_div_next : w_mul_next;
          if (r_cnt == '0)
            r_state <= S_FIX;
          else
            r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_state  <= S_DONE;
        end
        default: begin
          r_resp_data <= r_result;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - self-checking bench for ex_muldiv_seq against an arithmetic reference

module tb_ex_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fun_3;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic        flush;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_data;

  ex_muldiv_seq #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_fun_3  (req_fun_3),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .flush      (flush),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the strobe cycle.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    logic [31:0] exp;
    logic [31:0] data;
    int lat_exp, lat, busy_cnt;
    bit got;
    exp     = ref_model(f, a, b);
    lat_exp = exp_latency(f, a, b);
    chk({tag, " ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_fun_3 = f;
    req_op1   = a;
    req_op2   = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    got = 0; lat = 0; busy_cnt = 0; data = '0;
    for (int k = 1; k <= 60 && !got; k++) begin
      if (busy) busy_cnt++;
      if (resp_valid) begin
        got  = 1;
        lat  = k;
        data = resp_data;
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk({tag, " data"}, 64'(data), 64'(exp));
    chk({tag, " latency"}, 64'(lat), 64'(lat_exp));
    chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(lat_exp));
    @(posedge clk);
    @(negedge clk);
    chk({tag, " idle after"}, {62'd0, busy, resp_valid}, 64'd0);
    chk({tag, " data held"}, 64'(resp_data), 64'(exp));
    last_data = exp;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int rv_seen;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_fun_3 = '0;
    req_op1   = '0;
    req_op2   = '0;
    flush     = 1'b0;
    last_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset outputs", {busy, resp_valid, req_ready, resp_data}, {3'b001, 32'd0});
    rst = 1'b1;
    @(negedge clk);

    do_op("mul 10*7", 3'd0, 32'd10, 32'd7);
    do_op("mulh -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhu ff*ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhsu -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2);
    do_op("mul min*2", 3'd0, 32'h8000_0000, 32'd2);
    do_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    do_op("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    do_op("divu 10/3", 3'd5, 32'd10, 32'd3);
    do_op("remu 10/3", 3'd7, 32'd10, 32'd3);
    do_op("div 5/0", 3'd4, 32'd5, 32'd0);
    do_op("rem 5/0", 3'd6, 32'd5, 32'd0);
    do_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("divu min/-1", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF);

    // flush mid-multiply
    req_valid = 1'b1; req_fun_3 = 3'd0; req_op1 = 32'd123; req_op2 = 32'd456;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rv_seen = 0;
    for (int k = 1; k < 10; k++) begin
      if (resp_valid) rv_seen++;
      @(posedge clk);
      @(negedge clk);
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy/strobe", {62'd0, busy, resp_valid}, 64'd0);
    chk("flush no early strobe", 64'(rv_seen), 64'd0);
    chk("flush data kept", 64'(resp_data), 64'(last_data));
    do_op("mul 5*4 after flush", 3'd0, 32'd5, 32'd4);

    // flush during DONE of a special-case op
    req_valid = 1'b1; req_fun_3 = 3'd5; req_op1 = 32'd99; req_op2 = 32'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush in done strobe", {62'd0, busy, resp_valid}, 64'd2);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush in done idle", 64'(busy), 64'd0);
    chk("flush in done data", 64'(resp_data), 64'(last_data));

    // asynchronous reset in the middle of a divide
    req_valid = 1'b1; req_fun_3 = 3'd4; req_op1 = 32'd1000; req_op2 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k < 15; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk("async reset outputs", {busy, resp_valid, req_ready, resp_data}, {3'b001, 32'd0});
    @(negedge clk);
    rst = 1'b1;
    last_data = '0;
    rv_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (resp_valid || busy) rv_seen++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("no strobe after reset", 64'(rv_seen), 64'd0);

    // flush held in IDLE blocks acceptance
    flush = 1'b1;
    req_valid = 1'b1; req_fun_3 = 3'd0; req_op1 = 32'd3; req_op2 = 32'd3;
    rv_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy || resp_valid) rv_seen++;
    end
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flush blocks accept", 64'(rv_seen), 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      do_op($sformatf("rand%0d f%0d %h %h", i, f, a, b), f, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
